// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns the
// architectural HI/LO pair. It also handles the MTHI/MTLO writes and the
// stall generation for MFHI/MFLO (and any new mul/div) issued while busy.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | HI/LO stable; accepts Start or MTHI/MTLO writes
// RUN   | one shift-add (multiply) or restoring step (divide) per cycle
// FIX   | sign fix-up, HI/LO write-back, Done/DivZero pulse
module hilo_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             WrHi,
   input  logic             WrLo,
   input  logic [WIDTH-1:0] WrData,
   input  logic             RdReq,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Stall,
   output logic             Done,
   output logic             DivZero
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX
   } state_t;

   state_t             state;
   logic [5:0]         iter_cnt;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH-1:0]   mag_b;
   // Multiply: full {hi,lo} accumulator. Divide: low half holds the dividend,
   // which shifts out at the top while quotient bits shift in at the bottom.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;

   logic               signed_op;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ok;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               div_zero_op;

   assign signed_op = ~Op[0];
   assign abs_a     = (signed_op && A[WIDTH-1]) ? -A : A;
   assign abs_b     = (signed_op && B[WIDTH-1]) ? -B : B;

   assign mul_add   = acc[0] ? mag_b : {WIDTH{1'b0}};
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

   // 33-bit partial remainder; the subtraction result always fits in WIDTH
   // bits when it is kept, because the kept value is below the divisor.
   assign div_shift = {rem, acc[WIDTH-1]};
   assign div_ok    = (div_shift >= {1'b0, mag_b});
   assign div_sub   = div_shift[WIDTH-1:0] - mag_b;

   assign prod_fix  = neg_res ? -acc : acc;
   assign quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix   = neg_rem ? -rem : rem;
   assign div_zero_op = is_div && (mag_b == {WIDTH{1'b0}});

   assign Busy  = (state != ST_IDLE);
   assign Stall = Busy & (RdReq | Start);

   // Sequencer, datapath iteration and HI/LO ownership.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= ST_IDLE;
         iter_cnt <= 6'd0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         mag_b    <= {WIDTH{1'b0}};
         acc      <= {(2*WIDTH){1'b0}};
         rem      <= {WIDTH{1'b0}};
         Hi       <= {WIDTH{1'b0}};
         Lo       <= {WIDTH{1'b0}};
         Done     <= 1'b0;
         DivZero  <= 1'b0;
      end else begin
         Done    <= 1'b0;
         DivZero <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  state    <= ST_RUN;
                  is_div   <= Op[1];
                  neg_res  <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                  neg_rem  <= signed_op & A[WIDTH-1];
                  mag_b    <= abs_b;
                  acc      <= {{WIDTH{1'b0}}, abs_a};
                  rem      <= {WIDTH{1'b0}};
                  iter_cnt <= 6'd0;
               end else begin
                  // Start has priority: a same-cycle MTHI/MTLO is dropped.
                  if (WrHi) Hi <= WrData;
                  if (WrLo) Lo <= WrData;
               end
            end
            ST_RUN: begin
               if (is_div) begin
                  rem                <= div_ok ? div_sub : div_shift[WIDTH-1:0];
                  acc[WIDTH-1:0]     <= {acc[WIDTH-2:0], div_ok};
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
               iter_cnt <= iter_cnt + 6'd1;
               if (iter_cnt == 6'd31) state <= ST_FIX;
            end
            ST_FIX: begin
               state <= ST_IDLE;
               Done  <= 1'b1;
               if (div_zero_op) begin
                  DivZero <= 1'b1;
               end else if (is_div) begin
                  Hi <= rem_fix;
                  Lo <= quo_fix;
               end else begin
                  {Hi, Lo} <= prod_fix;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with hand-computed expected results.
module tb_hilo_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        wr_hi, wr_lo;
   logic [31:0] wr_data;
   logic        rd_req;
   logic [31:0] hi, lo;
   logic        busy, stall, done, div_zero;

   hilo_muldiv_ctrl #(.WIDTH(32)) dut (
      .Clk(clk), .Reset(reset), .Start(start), .Op(op), .A(a), .B(b),
      .WrHi(wr_hi), .WrLo(wr_lo), .WrData(wr_data), .RdReq(rd_req),
      .Hi(hi), .Lo(lo), .Busy(busy), .Stall(stall), .Done(done),
      .DivZero(div_zero)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   int          lat, busy_cnt, done_cnt, dz_cnt, stall_err;
   logic [31:0] hi_start;
   bit          mid_wr_lo   = 1'b0;
   bit          start_wr_hi = 1'b0;

   // Launch one op at edge 0 and follow it to Done (bounded), then one more edge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (start_wr_hi) begin
         wr_hi = 1'b1; wr_data = 32'hDEAD;
      end
      @(posedge clk); #1;
      start = 1'b0; wr_hi = 1'b0;
      hi_start = hi;
      lat = -1; busy_cnt = 0; done_cnt = 0; dz_cnt = 0;
      for (int e = 1; e <= 40 && lat < 0; e++) begin
         wr_lo = mid_wr_lo && (e == 3);
         if (wr_lo) wr_data = 32'h55;
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         wr_lo = 1'b0;
         if (done) begin
            done_cnt++;
            lat = e;
            if (div_zero) dz_cnt++;
         end
      end
      @(posedge clk); #1;
      if (done) done_cnt++;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; rd_req = 1'b0;
      #12;
      check_val("rst_hi", hi, 0);
      check_val("rst_lo", lo, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_divzero", div_zero, 0);
      @(negedge clk) reset = 1'b1;

      // MULTU max x max
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check_val("multu_max_lat", lat, 33);
      check_val("multu_max_busy_cycles", busy_cnt, 33);
      check_val("multu_max_done_pulses", done_cnt, 1);
      check_val("multu_max_busy_after", busy, 0);
      check_val("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

      // MULT -3 x 7
      run_op(2'b00, 32'hFFFFFFFD, 32'd7);
      check_val("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

      // DIV -7 / 2
      run_op(2'b10, 32'hFFFFFFF9, 32'd2);
      check_val("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

      // MTHI in IDLE
      @(negedge clk); wr_hi = 1'b1; wr_data = 32'h1234;
      @(posedge clk); #1; wr_hi = 1'b0;
      check_val("mthi_idle", hi, 32'h1234);
      check_val("mthi_lo_kept", lo, 32'hFFFFFFFD);

      // DIVU 7 / 2 with a simultaneous MTHI that must be dropped
      start_wr_hi = 1'b1;
      run_op(2'b11, 32'd7, 32'd2);
      start_wr_hi = 1'b0;
      check_val("start_wins_hi", hi_start, 32'h1234);
      check_val("divu_hilo", {hi, lo}, 64'h00000001_00000003);

      // DIV most-negative / -1 wraps
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
      check_val("div_wrap_hilo", {hi, lo}, 64'h00000000_80000000);

      // DIV 5 / 0 with an MTLO during RUN: nothing written
      mid_wr_lo = 1'b1;
      run_op(2'b10, 32'd5, 32'd0);
      mid_wr_lo = 1'b0;
      check_val("divzero_lat", lat, 33);
      check_val("divzero_pulse", dz_cnt, 1);
      check_val("divzero_done_pulses", done_cnt, 1);
      check_val("divzero_hilo_kept", {hi, lo}, 64'h00000000_80000000);

      // Stall while busy; second Start at cycle 5 ignored
      @(negedge clk); start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
      @(posedge clk); #1; start = 1'b0;
      stall_err = 0; done_cnt = 0; lat = -1;
      for (int c = 1; c <= 45; c++) begin
         rd_req = (c >= 2);
         start  = (c == 5);
         #1;
         if (c >= 2 && stall !== busy) stall_err++;
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = c;
               check_val("stall_release", stall, 0);
               check_val("stall_lo_at_release", lo, 32'd12);
            end
         end
      end
      rd_req = 1'b0;
      check_val("stall_tracking_errors", stall_err, 0);
      check_val("stall_lat", lat, 33);
      check_val("ignored_start_done_pulses", done_cnt, 1);
      check_val("ignored_start_lo", lo, 32'd12);

      // Reset mid-operation
      @(negedge clk); start = 1'b1; op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      #2; reset = 1'b0; #1;
      check_val("midrst_hi", hi, 0);
      check_val("midrst_lo", lo, 0);
      check_val("midrst_busy", busy, 0);
      done_cnt = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      check_val("midrst_no_done", done_cnt, 0);
      @(negedge clk) reset = 1'b1;
      run_op(2'b01, 32'd2, 32'd3);
      check_val("post_rst_lat", lat, 33);
      check_val("post_rst_hilo", {hi, lo}, 64'h00000000_00000006);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-iteration shift-add or restoring-divide loop. It writes HI/LO on completion and stalls the datapath whenever a later instruction needs HI/LO before the result is ready. MTHI/MTLO writes and the MFHI/MFLO read path (`Hi`/`Lo` into the HiLo writeback mux) also go through this block.

## Interface
- `WIDTH`, 32, operand and HI/LO width. Only 32 is verified.
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low. 0 clears all state.
- `Start`  in  1  launch the operation in `Op` using `A`/`B`. Sampled only in IDLE.
- `Op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`, `B`  in  WIDTH each  rs and rt operands.
- `WrHi`, `WrLo`  in  1 each  MTHI/MTLO write strobes.
- `WrData`  in  WIDTH  data for MTHI/MTLO.
- `RdReq`  in  1  an MFHI/MFLO (or a new mul/div) is in decode.
- `Hi`, `Lo`  out  WIDTH each  architectural HI/LO, registered.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Stall`  out  1  combinational: `Busy & (RdReq | Start)`.
- `Done`  out  1  one-cycle registered pulse when HI/LO is updated.
- `DivZero`  out  1  one-cycle pulse, coincident with `Done`, for a divide with B = 0.

## Operation
- States:
  - IDLE → RUN when `Start` is sampled.
  - RUN → FIX after 32 iterations.
  - FIX → IDLE.
- On the Start edge, the block latches `Op` and the operand magnitudes (|A|, |B| for signed ops, raw values for unsigned ops). It also latches the result-sign bits and clears the 6-bit iteration counter.
- RUN multiply: one shift-add per cycle on a 64-bit accumulator.
- RUN divide: one restoring step per cycle. Remainder is 33 bits wide; quotient bits shift into the low half.
- FIX sign rules:
  - Signed product: negated when sign(A) ≠ sign(B).
  - Signed quotient: negated when sign(A) ≠ sign(B).
  - Remainder: takes the sign of A.
  - Results are truncated toward zero.
- FIX writes {HI,LO} = 64-bit product for multiplies, and HI = remainder, LO = quotient for divides.
- Divide by zero runs the full latency. HI/LO are NOT written; `DivZero` and `Done` pulse.
- Signed divide of 0x80000000 by −1 gives LO = 0x80000000, HI = 0. This is natural 32-bit wrap; no special case is needed.
- `Start` while `Busy`: ignored. `Stall` holds the requester until IDLE.
- `WrHi`/`WrLo` in IDLE: the selected register loads `WrData` at the next edge.
- `WrHi`/`WrLo` while `Busy`: ignored. MIPS leaves this undefined; the block defines it as a drop.
- `Start` together with `WrHi`/`WrLo` in IDLE: `Start` wins and the write is dropped.

## Timing
- Reset values: `Hi` = `Lo` = 0, `Busy` = 0, `Done` = 0, `DivZero` = 0, state IDLE, counter 0.
- Edge numbering starts at the edge where `Start` is sampled (edge 0). `Busy` rises after edge 0.
- Edges 1–32 each perform one iteration; state moves to FIX after edge 32.
- Edge 33 writes HI/LO and sets `Done` (and `DivZero` if applicable) for exactly one cycle. State returns to IDLE and `Busy` falls.
- `Busy` is high for exactly 33 cycles. The earliest next `Start` is sampled at edge 34; back-to-back operation is allowed with no gap beyond that.
- `Stall` is combinational and is valid in the same cycle as `RdReq`. It deasserts in the cycle in which `Busy` falls, so an MFHI issued then reads the new `Hi`.
- `Reset` low mid-operation asynchronously clears everything to the reset values. No partial result is written.

## Test plan
- MULTU A = 0xFFFFFFFF, B = 0xFFFFFFFF → `Busy` high 33 cycles, then HI = 0xFFFFFFFE, LO = 0x00000001 with a one-cycle `Done` at edge 33.
- MULT A = −3 (0xFFFFFFFD), B = 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Next, DIV A = −7, B = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Next, DIVU A = 7, B = 2 → LO = 3, HI = 1.
- DIV A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0. Then DIV A = 5, B = 0 → HI/LO unchanged, `DivZero` and `Done` pulse at edge 33.
- Start MULTU 3×4, then hold `RdReq` = 1 from cycle 2:
  - `Stall` is 1 through cycle 33 and 0 once `Busy` falls, when `Lo` = 12.
  - A second `Start` at cycle 5 is ignored (result is still 12, no second `Done`).
- `WrHi` with 0x1234 in IDLE → `Hi` = 0x1234 next edge. `WrLo` with 0x55 during RUN → dropped. `Start` together with `WrHi` in IDLE → write dropped and the op result lands.
- Start MULT, drive `Reset` = 0 at cycle 10 → `Hi` = `Lo` = 0 and `Busy` = 0 immediately, no `Done`. After `Reset` returns to 1, a fresh MULTU 2×3 gives LO = 6 at edge 33.
